// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: command-driven controller for a WIDTH-bit bank of JK cells.
// Mask commands (CLR/SET/TGL) apply one cycle of J/K drive. CNT_UP steps the
// bank as a binary counter for cmd_count cycles.
// Optional feature macro: JK_SEQ_DOWN_EN enables CNT_DN (op 101). When the macro
// is undefined, op 101 is reserved and behaves as a NOP.
module jk_bank_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_op,
    input  logic [WIDTH-1:0] i_cmd_mask,
    input  logic [CNT_W-1:0] i_cmd_count,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_jk_j,
    output logic [WIDTH-1:0] o_jk_k,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [2:0] OP_CLR    = 3'b001;
    localparam logic [2:0] OP_SET    = 3'b010;
    localparam logic [2:0] OP_TGL    = 3'b011;
    localparam logic [2:0] OP_CNT_UP = 3'b100;
`ifdef JK_SEQ_DOWN_EN
    localparam logic [2:0] OP_CNT_DN = 3'b101;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_mask;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_t_up;
    logic [WIDTH-1:0] w_t;
    logic             w_accept;
    logic             w_is_cnt;
`ifdef JK_SEQ_DOWN_EN
    logic             r_down;
    logic [WIDTH-1:0] w_t_dn;
`endif

    // Increment step vector: a cell toggles when every lower cell is 1
    always_comb begin : p_t_up
        logic c;
        c = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            w_t_up[i] = c;
            c         = c & r_q[i];
        end
    end

`ifdef JK_SEQ_DOWN_EN
    // Decrement step vector: a cell toggles when every lower cell is 0
    always_comb begin : p_t_dn
        logic c;
        c = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            w_t_dn[i] = c;
            c         = c & ~r_q[i];
        end
    end

    // Count command classification and step vector selection
    always_comb begin
        w_is_cnt = (i_cmd_op == OP_CNT_UP) || (i_cmd_op == OP_CNT_DN);
        w_t      = r_down ? w_t_dn : w_t_up;
    end
`else
    // Count command classification; op 101 falls through to the APPLY path
    always_comb begin
        w_is_cnt = (i_cmd_op == OP_CNT_UP);
        w_t      = w_t_up;
    end
`endif

    // Next-state and per-cycle J/K drive
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_j         = '0;
        w_k         = '0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    w_accept = 1'b1;
                    if (w_is_cnt) begin
                        w_state_nxt = (i_cmd_count == '0) ? S_DONE : S_COUNT;
                    end else begin
                        w_state_nxt = S_APPLY;
                    end
                end
            end
            S_APPLY: begin
                case (r_op)
                    OP_CLR:  w_k = r_mask;
                    OP_SET:  w_j = r_mask;
                    OP_TGL:  begin w_j = r_mask; w_k = r_mask; end
                    default: ;
                endcase
                w_state_nxt = S_DONE;
            end
            S_COUNT: begin
                w_j       = w_t;
                w_k       = w_t;
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) w_state_nxt = S_DONE;
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, command latch, and JK bank update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_mask  <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
`ifdef JK_SEQ_DOWN_EN
            r_down  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_q     <= (w_j & ~r_q) | (~w_k & r_q);
            if (w_accept) begin
                r_op   <= i_cmd_op;
                r_mask <= i_cmd_mask;
                r_cnt  <= i_cmd_count;
`ifdef JK_SEQ_DOWN_EN
                r_down <= (i_cmd_op == OP_CNT_DN);
`endif
            end else begin
                r_cnt <= w_cnt_nxt;
            end
        end
    end

    assign o_q         = r_q;
    assign o_jk_j      = w_j;
    assign o_jk_k      = w_k;
    assign o_cmd_ready = (r_state == S_IDLE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Self-checking bench for jk_bank_sequencer against an arithmetic bank model.
module tb_jk_bank_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_mask;
    logic [3:0] cmd_count;
    logic [7:0] q;
    logic [7:0] jk_j;
    logic [7:0] jk_k;
    logic       busy;
    logic       done;

    int         checks = 0;
    int         passes = 0;
    logic [7:0] m_q;

    jk_bank_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_mask(cmd_mask), .i_cmd_count(cmd_count),
        .o_q(q), .o_jk_j(jk_j), .o_jk_k(jk_k),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bits that change when v is incremented / decremented
    function automatic logic [7:0] t_up(input logic [7:0] v);
        logic [8:0] s;
        s = {1'b0, v} + 9'd1;
        return 8'({1'b0, v} ^ s);
    endfunction

    function automatic logic [7:0] t_dn(input logic [7:0] v);
        logic [8:0] s;
        s = {1'b0, v} - 9'd1;
        return 8'({1'b0, v} ^ s);
    endfunction

    function automatic logic [7:0] mask_result(input logic [2:0] op, input logic [7:0] v,
                                               input logic [7:0] m);
        case (op)
            3'b001:  return v & ~m;
            3'b010:  return v | m;
            3'b011:  return v ^ m;
            default: return v;
        endcase
    endfunction

    // Present a command at a negedge; returns at the negedge after the accept edge
    task automatic issue(input logic [2:0] op, input logic [7:0] m, input logic [3:0] n);
        cmd_op = op; cmd_mask = m; cmd_count = n; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            $display("FAIL wait_idle: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
        end
    endtask

    task automatic load_q(input logic [7:0] v);
        issue(3'b001, 8'hFF, 4'd0); wait_idle();
        issue(3'b010, v, 4'd0);     wait_idle();
        m_q = v;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_mask = '0; cmd_count = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        load_q(8'hA5);
        checks++; if (q !== 8'hA5) $display("FAIL preload_a5: q=%h required a5", q); else passes++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_q = 8'h00;
        checks++; if (q !== 8'h00) $display("FAIL reset_q: q=%h required 00", q); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: busy=%b required 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: done=%b required 0", done); else passes++;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: ready=%b required 1", cmd_ready); else passes++;
        checks++; if ({jk_j, jk_k} !== 16'h0) $display("FAIL reset_jk: j=%h k=%h required 0", jk_j, jk_k); else passes++;
    endtask

    task automatic test_mask_ops();
        logic [2:0] ops [3];
        logic [7:0] msk [3];
        logic [2:0] op;
        logic [7:0] m, ej, ek;
        ops = '{3'b010, 3'b011, 3'b001};
        msk = '{8'hF0, 8'h3C, 8'h80};
        for (int i = 0; i < 11; i++) begin
            if (i < 3) begin op = ops[i]; m = msk[i]; end
            else begin op = 3'($urandom_range(1, 3)); m = 8'($urandom); end
            ej = (op == 3'b010 || op == 3'b011) ? m : 8'h00;
            ek = (op == 3'b001 || op == 3'b011) ? m : 8'h00;
            issue(op, m, 4'd0);
            checks++; if (jk_j !== ej || jk_k !== ek) $display("FAIL mask_jk[%0d]: j=%h k=%h required %h %h", i, jk_j, jk_k, ej, ek); else passes++;
            checks++; if (q !== m_q || done !== 1'b0 || busy !== 1'b1) $display("FAIL mask_apply[%0d]: q=%h done=%b busy=%b required %h 0 1", i, q, done, busy, m_q); else passes++;
            m_q = mask_result(op, m_q, m);
            @(negedge clk);
            checks++; if (q !== m_q || done !== 1'b1) $display("FAIL mask_done[%0d]: q=%h done=%b required %h 1", i, q, done, m_q); else passes++;
            @(negedge clk);
            checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL mask_idle[%0d]: done=%b ready=%b required 0 1", i, done, cmd_ready); else passes++;
            if (i == 2) begin
                checks++; if (q !== 8'h4C) $display("FAIL mask_seq: q=%h required 4c", q); else passes++;
            end
        end
    endtask

    task automatic test_count_up();
        logic [7:0] start;
        int n, busy_cycles, dones;
        for (int r = 0; r < 7; r++) begin
            if (r == 0) begin start = 8'hFD; n = 5; end
            else begin start = 8'($urandom); n = $urandom_range(1, 15); end
            load_q(start);
            issue(3'b100, 8'h00, 4'(n));
            busy_cycles = 0; dones = 0;
            for (int s = 0; s < n; s++) begin
                checks++; if (q !== m_q || jk_j !== t_up(m_q) || jk_k !== t_up(m_q) || done !== 1'b0)
                    $display("FAIL cnt_step[%0d.%0d]: q=%h j=%h k=%h done=%b required q=%h jk=%h", r, s, q, jk_j, jk_k, done, m_q, t_up(m_q));
                else passes++;
                if (r == 0 && s == 0) begin
                    checks++; if (jk_j !== 8'h03) $display("FAIL cnt_first_j: j=%h required 03", jk_j); else passes++;
                end
                if (r == 0 && s == 2) begin
                    checks++; if (jk_j !== 8'hFF) $display("FAIL cnt_wrap_j: j=%h required ff", jk_j); else passes++;
                end
                m_q = m_q + 8'd1;
                busy_cycles += int'(busy); dones += int'(done);
                @(negedge clk);
            end
            checks++; if (q !== m_q || done !== 1'b1 || {jk_j, jk_k} !== 16'h0) $display("FAIL cnt_done[%0d]: q=%h done=%b j=%h required %h 1 00", r, q, done, jk_j, m_q); else passes++;
            busy_cycles += int'(busy); dones += int'(done);
            @(negedge clk);
            busy_cycles += int'(busy); dones += int'(done);
            checks++; if (busy_cycles != n + 1 || dones != 1) $display("FAIL cnt_busy[%0d]: busy=%0d dones=%0d required %0d 1", r, busy_cycles, dones, n + 1); else passes++;
            if (r == 0) begin
                checks++; if (q !== 8'h02) $display("FAIL cnt_final: q=%h required 02", q); else passes++;
            end
        end
    endtask

    task automatic test_back_to_back();
        load_q(8'h7E);
        cmd_op = 3'b100; cmd_mask = 8'h00; cmd_count = 4'd3; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_op = 3'b010; cmd_mask = 8'h0F; cmd_count = 4'd0;
        for (int s = 0; s < 3; s++) begin
            checks++; if (cmd_ready !== 1'b0 || q !== m_q) $display("FAIL b2b_step[%0d]: ready=%b q=%h required 0 %h", s, cmd_ready, q, m_q); else passes++;
            m_q = m_q + 8'd1;
            @(negedge clk);
        end
        checks++; if (cmd_ready !== 1'b0 || done !== 1'b1 || q !== m_q) $display("FAIL b2b_done: ready=%b done=%b q=%h required 0 1 %h", cmd_ready, done, q, m_q); else passes++;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_idle: ready=%b busy=%b required 1 0", cmd_ready, busy); else passes++;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (busy !== 1'b1 || jk_j !== 8'h0F || q !== m_q) $display("FAIL b2b_second: busy=%b j=%h q=%h required 1 0f %h", busy, jk_j, q, m_q); else passes++;
        m_q = m_q | 8'h0F;
        @(negedge clk);
        checks++; if (q !== m_q || done !== 1'b1) $display("FAIL b2b_result: q=%h done=%b required %h 1", q, done, m_q); else passes++;
        wait_idle();
    endtask

    task automatic test_reset_abort();
        int dones;
        load_q(8'h00);
        issue(3'b100, 8'h00, 4'd10);
        @(negedge clk);
        checks++; if (q !== 8'h01) $display("FAIL abort_step: q=%h required 01", q); else passes++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_q = 8'h00;
        checks++; if (q !== 8'h00 || busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL abort_state: q=%h busy=%b ready=%b required 00 0 1", q, busy, cmd_ready); else passes++;
        dones = int'(done);
        repeat (12) begin
            @(negedge clk);
            dones += int'(done) + int'(busy);
        end
        checks++; if (dones != 0 || q !== 8'h00) $display("FAIL abort_quiet: done/busy=%0d q=%h required 0 00", dones, q); else passes++;
    endtask

    task automatic test_edge_ops();
        load_q(8'h5A);
        issue(3'b100, 8'hFF, 4'd0);
        checks++; if (done !== 1'b1 || q !== m_q || {jk_j, jk_k} !== 16'h0) $display("FAIL cnt0: done=%b q=%h j=%h k=%h required 1 %h 0 0", done, q, jk_j, jk_k, m_q); else passes++;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) $display("FAIL cnt0_idle: ready=%b done=%b required 1 0", cmd_ready, done); else passes++;
        issue(3'b111, 8'hFF, 4'd3);
        checks++; if ({jk_j, jk_k} !== 16'h0 || busy !== 1'b1) $display("FAIL op7_apply: j=%h k=%h busy=%b required 0 0 1", jk_j, jk_k, busy); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b1 || q !== m_q) $display("FAIL op7_done: done=%b q=%h required 1 %h", done, q, m_q); else passes++;
        wait_idle();
`ifdef JK_SEQ_DOWN_EN
        load_q(8'h01);
        issue(3'b101, 8'h00, 4'd2);
        for (int s = 0; s < 2; s++) begin
            checks++; if (q !== m_q || jk_j !== t_dn(m_q)) $display("FAIL dn_step[%0d]: q=%h j=%h required %h %h", s, q, jk_j, m_q, t_dn(m_q)); else passes++;
            m_q = m_q - 8'd1;
            @(negedge clk);
        end
        checks++; if (q !== 8'hFF || done !== 1'b1) $display("FAIL dn_done: q=%h done=%b required ff 1", q, done); else passes++;
`else
        issue(3'b101, 8'hFF, 4'd2);
        checks++; if ({jk_j, jk_k} !== 16'h0 || busy !== 1'b1) $display("FAIL op5_apply: j=%h k=%h busy=%b required 0 0 1", jk_j, jk_k, busy); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b1 || q !== m_q) $display("FAIL op5_done: done=%b q=%h required 1 %h", done, q, m_q); else passes++;
`endif
        wait_idle();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mask_ops();
        test_count_up();
        test_back_to_back();
        test_reset_abort();
        test_edge_ops();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
